// File: rtl/sram_resp_if.sv
// Request/response bundle between a requester (fetch or data-access stage)
// and the single-port SRAM responder.
interface sram_resp_if;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_resp.sv
// Single-port SRAM responder: 1-cycle read latency, byte-lane writes,
// address-window check with sticky out-of-window capture, saturating access counters.
module sram_resp #(
    parameter logic [31:0] BASE     = 32'h1c00_0000,
    parameter int          DEPTH    = 4096,
    parameter logic [31:0] OOR_DATA = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    sram_resp_if.slave       bus,
    output logic             oor_err,
    output logic [31:0]      oor_addr,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

    logic [31:0]    mem [DEPTH];
    logic [31:0]    rdata_q;
    logic [AW+1:0]  offset;
    logic [AW-1:0]  idx;
    logic           hit;
    logic           is_write;
    logic           wr_hit;

    // 33-bit compare so a window ending at the top of the address space cannot wrap
    assign hit      = ({1'b0, bus.sram_addr} >= {1'b0, BASE}) &&
                      ({1'b0, bus.sram_addr} <  LIMIT);
    assign offset   = bus.sram_addr[AW+1:0] - BASE[AW+1:0];
    assign idx      = AW'(offset >> 2);
    assign is_write = |bus.sram_we;
    assign wr_hit   = !reset && bus.sram_en && hit && is_write;

    assign bus.sram_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.sram_we[b]) begin
                    mem[idx][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // rdata samples mem before the write lands, giving read-first behaviour
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            oor_err  <= 1'b0;
            oor_addr <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else if (bus.sram_en) begin
            if (hit) begin
                rdata_q <= mem[idx];
                if (is_write) begin
                    if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
                end else begin
                    if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
                end
            end else begin
                rdata_q <= OOR_DATA;
                if (!oor_err) oor_addr <= bus.sram_addr;
                oor_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/sram_resp.md
Name: sram_resp

Overview:
- Synchronous single-port SRAM responder. It is the memory end of the sram_en/we/addr/wdata/rdata interface that the fetch stage (and later the data-access stage) drives.
- Fixed 1-cycle read latency with byte-lane writes and an address-window check. Out-of-window accesses are flagged.
- Holds program/data storage for the CPU testbench. Also keeps simple access statistics for debug.

Parameters:
- BASE, 32'h1c00_0000, byte address of word 0 of the window
- DEPTH, 4096, number of 32-bit words (power of 2, 16..65536)
- OOR_DATA, 32'h0000_0000, read data returned for out-of-window reads
- CNT_W, 32, width of the access counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- sram_en  in  1  access request this cycle
- sram_we  in  4  byte write enables, bit i writes byte lane i (wdata[8i+7:8i])
- sram_addr  in  32  byte address; bits [1:0] ignored
- sram_wdata  in  32  write data
- sram_rdata  out  32  read data, valid the cycle after an accepted read
- oor_err  out  1  sticky flag, set by any out-of-window access
- oor_addr  out  32  address of the first out-of-window access since reset
- rd_cnt  out  CNT_W  accepted in-window reads
- wr_cnt  out  CNT_W  accepted in-window writes (any we bit set)

Behaviour:
- Window hit: sram_addr >= BASE and sram_addr < BASE + 4*DEPTH, computed as an unsigned 33-bit compare so there is no wrap at 32'hFFFF_FFFC.
- Word index = (sram_addr - BASE)[log2(DEPTH)+1:2].
- Reset values:
  - sram_rdata = 0, oor_err = 0, oor_addr = 0, rd_cnt = 0, wr_cnt = 0.
  - Memory array contents are NOT reset; they are preloaded by the bench only.
- Accesses presented while reset = 1 are ignored: no write, no counter update, rdata held at 0.
- Read (en = 1, we = 4'b0000):
  - Hit: at the next edge sram_rdata <= mem[idx]; rd_cnt increments.
  - Miss: sram_rdata <= OOR_DATA.
- Write (en = 1, we != 0):
  - Hit: mem[idx] is updated per byte lane at the edge; wr_cnt increments.
  - sram_rdata <= old mem[idx] (read-first), so a write cycle also returns the pre-write word.
  - Miss: no array change; sram_rdata <= OOR_DATA.
- Idle (en = 0): sram_rdata holds its previous value; no counter or flag change.
- Back-to-back: a read at cycle n+1 of a word written at cycle n returns the new data, with no bypass hazard.
- Out-of-window access (en = 1, miss, reset = 0):
  - oor_err is set and remains set until reset.
  - oor_addr captures sram_addr only when oor_err was 0 before the edge.
- Counters saturate at all-ones and do not wrap.
- Latency is exactly 1 cycle, with no stall or ready signal. The requester must treat rdata as the response to the previous cycle's request.
- Reset mid-operation: a request in the same cycle as reset is dropped. After reset deassertion the first request is serviced normally, including the first fetch at BASE issued with the fetch PC's reset value 32'h1bff_fffc + 4.

Test Plan:
1. Preload mem[0] = 32'h0280_0c0c and mem[1] = 32'h1234_5678. Release reset, en = 1, addr = 32'h1c00_0000 then 32'h1c00_0004 -> rdata = 32'h0280_0c0c one cycle after the first request, then 32'h1234_5678; rd_cnt = 2.
2. Byte writes: mem[2] = 32'hAABB_CCDD. Write we = 4'b0101, wdata = 32'h1122_3344 to 32'h1c00_0008 -> same-cycle response rdata = 32'hAABB_CCDD (read-first). The following read returns 32'hAA22_CC44; wr_cnt = 1.
3. Idle hold: read 32'h1c00_0000, then en = 0 for 3 cycles -> rdata stays at mem[0] and rd_cnt is unchanged.
4. Out of window: read 32'h1bff_fffc, then write 32'h1c00_4000 (DEPTH = 4096) -> rdata = OOR_DATA; oor_err = 1; oor_addr = 32'h1bff_fffc (not overwritten by the second miss); no counter change; mem[0] unchanged.
5. Reset mid-stream: issue a write to 32'h1c00_000c with reset = 1 -> mem[3] unchanged, rdata = 0, all counters 0, oor_err cleared. A read of 32'h1c00_000c after reset returns the preloaded value.
6. Saturation with CNT_W = 4: issue 20 consecutive reads -> rd_cnt = 4'hF and stays at 4'hF.
